// File: rtl/adc_read_controller.sv
// adc_read_controller: owns the ADC. Powers it up, issues reads, waits for
// conversion completion and captures the result. Two requesters share it
// under round-robin arbitration (0: auto-read logic, 1: command logic).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no read in flight; adc_enable follows keep_enabled; samples req
// POWER_UP | adc_enable high, waiting POWER_UP_CYCLES before the first read
// READ     | adc_read high, waiting for completion or timeout
// DONE     | ack pulse cycle; adc_read low, returns to IDLE
`timescale 1ns/1ps
module adc_read_controller #(
  parameter int POWER_UP_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic        keep_enabled,
  output logic [1:0]  ack,
  output logic [15:0] result,
  output logic        result_error,
  output logic        busy,
  output logic        adc_enable,
  output logic        adc_read,
  input  logic        adc_conversion_complete,
  input  logic [15:0] adc_value
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Down-counter loads: the terminal count (zero) lands exactly on the
  // POWER_UP_CYCLES-th / TIMEOUT_CYCLES-th edge after the load.
  localparam logic [CW-1:0] PU_LOAD = CW'(POWER_UP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, POWER_UP, READ, DONE} state_t;

  state_t        state;
  logic          grant;
  logic          last_grant;
  logic          pick;
  logic [CW-1:0] cnt;

  // Round-robin pick: a lone request wins outright; on contention the
  // requester that was not served last wins.
  always_comb begin
    pick = req[1];
    if (req == 2'b11) pick = ~last_grant;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      cnt          <= '0;
      ack          <= 2'b00;
      result       <= 16'h0000;
      result_error <= 1'b0;
      busy         <= 1'b0;
      adc_enable   <= 1'b0;
      adc_read     <= 1'b0;
    end else begin
      ack <= 2'b00;
      case (state)
        IDLE: begin
          adc_read <= 1'b0;
          if (req != 2'b00) begin
            grant      <= pick;
            last_grant <= pick;
            busy       <= 1'b1;
            if (adc_enable) begin
              state    <= READ;
              adc_read <= 1'b1;
              cnt      <= TO_LOAD;
            end else begin
              adc_enable <= 1'b1;
              state      <= POWER_UP;
              cnt        <= PU_LOAD;
            end
          end else begin
            adc_enable <= keep_enabled;
          end
        end
        POWER_UP: begin
          if (!req[grant]) begin
            state    <= IDLE;
            adc_read <= 1'b0;
            busy     <= 1'b0;
          end else if (cnt == '0) begin
            state    <= READ;
            adc_read <= 1'b1;
            cnt      <= TO_LOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        READ: begin
          // Abort beats a same-edge completion; completion beats timeout.
          if (!req[grant]) begin
            state    <= IDLE;
            adc_read <= 1'b0;
            busy     <= 1'b0;
          end else if (adc_conversion_complete) begin
            result       <= adc_value;
            result_error <= 1'b0;
            adc_read     <= 1'b0;
            ack[grant]   <= 1'b1;
            state        <= DONE;
          end else if (cnt == '0) begin
            result_error <= 1'b1;
            adc_read     <= 1'b0;
            ack[grant]   <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          adc_read <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_read_controller.sv
// Self-checking bench for adc_read_controller: an ADC model answers reads
// after a programmable latency; a transaction-level reference model predicts
// grants, read-start delay, ack time, result and error flag.
`timescale 1ns/1ps
module tb_adc_read_controller;

  localparam int P  = 16;
  localparam int TO = 1100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic        keep_enabled = 1'b0;
  logic [1:0]  ack;
  logic [15:0] result;
  logic        result_error;
  logic        busy;
  logic        adc_enable;
  logic        adc_read;
  logic        adc_conversion_complete = 1'b0;
  logic [15:0] adc_value = 16'h0000;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  int          adc_lat = 0;
  logic [15:0] adc_val = 16'h0000;
  int          bfm_cnt = 0;
  logic        rd_q = 1'b0;

  int   low_run = 1000;
  int   min_low = 1000;
  logic rd_m = 1'b0;

  logic        m_last = 1'b1;
  logic [15:0] m_res = 16'h0000;
  logic        m_err = 1'b0;

  adc_read_controller #(.POWER_UP_CYCLES(P), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .keep_enabled(keep_enabled),
    .ack(ack), .result(result), .result_error(result_error), .busy(busy),
    .adc_enable(adc_enable), .adc_read(adc_read),
    .adc_conversion_complete(adc_conversion_complete), .adc_value(adc_value)
  );

  always #5 clk = ~clk;

  // Edge counter used to time events
  always @(posedge clk) cyc++;

  // ADC model: completion pulse sampled on the adc_lat-th edge after adc_read rises
  always @(negedge clk) begin
    adc_conversion_complete = 1'b0;
    if (rst) bfm_cnt = 0;
    else if (adc_read && !rd_q) bfm_cnt = adc_lat;
    if (bfm_cnt != 0) begin
      bfm_cnt--;
      if (bfm_cnt == 0) begin
        adc_conversion_complete = 1'b1;
        adc_value = adc_val;
      end
    end
    rd_q = adc_read;
  end

  // Shortest low gap seen before any adc_read rising edge
  always @(negedge clk) begin
    if (!adc_read) low_run++;
    else begin
      if (!rd_m && low_run < min_low) min_low = low_run;
      low_run = 0;
    end
    rd_m = adc_read;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic pick_model(input logic [1:0] r);
    if (r == 2'b11) return !m_last;
    return (r == 2'b10);
  endfunction

  task automatic do_read(input logic [1:0] r, input int lat, input logic [15:0] v, input logic ke);
    int s, rise, w, dl;
    logic g, er;
    @(negedge clk);
    keep_enabled = ke; adc_lat = lat; adc_val = v;
    repeat (2) @(negedge clk);
    g = pick_model(r);
    m_last = g;
    req = r;
    s = cyc + 1;
    @(negedge clk);
    chk("busy_rise", 32'(busy), 1);
    chk("en_on", 32'(adc_enable), 1);
    w = 0;
    while (!adc_read && w < P + 5) begin @(negedge clk); w++; end
    rise = cyc;
    chk("read_start", 32'(rise - s), ke ? 0 : P);
    if (lat != 0 && lat <= TO) begin dl = lat; er = 1'b0; end
    else begin dl = TO; er = 1'b1; end
    w = 0;
    while (ack == 2'b00 && w < TO + 10) begin @(negedge clk); w++; end
    chk("ack_time", 32'(cyc - rise), 32'(dl));
    chk("ack_who", 32'(ack), g ? 32'd2 : 32'd1);
    chk("err", 32'(result_error), 32'(er));
    if (!er) m_res = v;
    m_err = er;
    chk("result", 32'(result), 32'(m_res));
    chk("rd_low_at_ack", 32'(adc_read), 0);
    req = 2'b00;
    @(negedge clk);
    chk("ack_1cyc", 32'(ack), 0);
    chk("busy_fall", 32'(busy), 0);
    chk("en_done", 32'(adc_enable), 1);
    @(negedge clk);
    chk("en_idle", 32'(adc_enable), 32'(ke));
  endtask

  task automatic do_abort();
    int w, nack;
    @(negedge clk);
    keep_enabled = 1'b0; adc_lat = 400; adc_val = 16'hDEAD;
    repeat (2) @(negedge clk);
    m_last = pick_model(2'b01);
    req = 2'b01;
    w = 0;
    while (!adc_read && w < P + 10) begin @(negedge clk); w++; end
    chk("abort_started", 32'(adc_read), 1);
    repeat (300) @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    chk("abort_rd_fall", 32'(adc_read), 0);
    chk("abort_busy", 32'(busy), 0);
    nack = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack != 2'b00) nack++;
    end
    chk("abort_no_ack", 32'(nack), 0);
    chk("abort_result", 32'(result), 32'(m_res));
    chk("abort_err", 32'(result_error), 32'(m_err));
    chk("abort_en_off", 32'(adc_enable), 0);
  endtask

  task automatic do_reset_mid_read();
    int w;
    @(negedge clk);
    keep_enabled = 1'b0; adc_lat = 800; adc_val = 16'h1234;
    repeat (2) @(negedge clk);
    m_last = pick_model(2'b01);
    req = 2'b01;
    w = 0;
    while (!adc_read && w < P + 10) begin @(negedge clk); w++; end
    chk("rst_started", 32'(adc_read), 1);
    repeat (50) @(negedge clk);
    rst = 1'b1; req = 2'b00;
    #1;
    chk("rst_rd", 32'(adc_read), 0);
    chk("rst_en", 32'(adc_enable), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_result", 32'(result), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_last = 1'b1; m_res = 16'h0000; m_err = 1'b0;
    do_read(2'b11, $urandom_range(1, 1000), 16'($urandom), 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("init_ack", 32'(ack), 0);
    chk("init_result", 32'(result), 0);
    chk("init_err", 32'(result_error), 0);
    chk("init_busy", 32'(busy), 0);
    chk("init_en", 32'(adc_enable), 0);
    chk("init_rd", 32'(adc_read), 0);

    do_read(2'b01, 1000, 16'hA5C3, 1'b0);
    do_read(2'b10, TO, 16'h5A3C, 1'b1);
    do_read(2'b01, 0, 16'hFFFF, 1'b0);
    for (int i = 0; i < 4; i++)
      do_read(2'b11, $urandom_range(1, 1000), 16'($urandom), 1'($urandom));
    for (int i = 0; i < 8; i++)
      do_read(2'($urandom_range(1, 3)),
              ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 1000),
              16'($urandom), 1'($urandom));
    do_abort();
    do_reset_mid_read();
    chk("read_gap_ge2", 32'(min_low >= 2), 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_read_controller.md
# adc_read_controller

Synthesizable sequencer that owns the tag's ADC. It powers the ADC up, issues reads, waits for conversion completion and captures the result. It shares the ADC between two requesters (index 0: AUTO_READ logic, index 1: SET_SIGNAL/command logic) using round-robin arbitration. It sits between the command layer and the analogue ADC macro, or the ADC bus-functional model in simulation.

## Interface
Parameters:
- POWER_UP_CYCLES, default 16: cycles adc_enable must be high before adc_read may rise. Must be ≥ 1.
- TIMEOUT_CYCLES, default 4095: maximum cycles adc_read stays high awaiting completion. Must exceed the ADC's worst case, which is 2000.

Ports:
- clk  input  1: system clock; all logic is on the rising edge.
- rst  input  1: asynchronous, active-high reset.
- req  input  2: per-requester read request, level. Held until the matching ack, or dropped to abort.
- keep_enabled  input  1: keep adc_enable high while idle.
- ack  output  2: one-cycle pulse on the requester whose read finished.
- result  output  16: last captured adc_value. Stable until the next successful capture.
- result_error  output  1: qualifies ack. 1 means timeout; result is unchanged in that case.
- busy  output  1: high in any state other than IDLE.
- adc_enable  output  1: ADC power.
- adc_read  output  1: ADC read start; rising edge starts a conversion.
- adc_conversion_complete  input  1: single-cycle completion pulse from the ADC.
- adc_value  input  16: ADC result, valid while adc_conversion_complete is high.

## Operation
- All outputs are registered.
- Reset values: ack=0, result=0, result_error=0, busy=0, adc_enable=0, adc_read=0.
- Internal reset values: state=IDLE, last_grant=1, so requester 0 wins the first contention.
- States: IDLE, POWER_UP, READ, DONE.
- IDLE
  - adc_read=0.
  - adc_enable follows keep_enabled, registered.
  - If req≠0, latch grant:
    - Only one bit set: grant that requester.
    - Both bits set: grant the requester that is not last_grant.
    - Then set last_grant to the granted requester.
  - If adc_enable is already 1, go to READ. Otherwise set adc_enable=1 and go to POWER_UP.
- POWER_UP
  - Counts POWER_UP_CYCLES cycles, then goes to READ.
- READ
  - adc_read=1; the timeout counter counts from 0.
  - adc_conversion_complete=1:
    - result<=adc_value, result_error<=0, adc_read<=0.
    - ack[grant]<=1, go to DONE.
  - Counter reaches TIMEOUT_CYCLES with no completion:
    - result_error<=1, adc_read<=0.
    - ack[grant]<=1, result kept, go to DONE.
  - Completion on the same edge as the timeout: completion wins, result_error=0.
- DONE
  - ack is high for this single cycle.
  - adc_enable stays 1; go to IDLE.
- Abort: if req[grant] is 0 in POWER_UP or READ, go to IDLE on that edge.
  - adc_read<=0; no ack; result and result_error unchanged.
  - A completion pulse arriving on the abort edge is ignored.
  - adc_enable then follows keep_enabled.
- Requests are sampled only in IDLE. A requester must drop req in the cycle after ack to avoid being re-served.
- Counter width is $clog2(TIMEOUT_CYCLES+1); the counter is reused for POWER_UP.

## Timing
- Cold read, ADC disabled:
  - Edge 0: IDLE samples req.
  - Edge 1: adc_enable=1.
  - Edge 1+POWER_UP_CYCLES: adc_read=1.
  - ADC completes L cycles after adc_read rises.
  - ack and result are valid on the edge after the completion is sampled.
- Warm read, adc_enable already 1: adc_read=1 on edge 1.
- Between reads, adc_read is low for ≥2 cycles (DONE plus IDLE), so the ADC always sees a fresh rising edge.
- busy rises on the edge after req is sampled and falls on the edge entering IDLE.
- Reset asserted mid-operation:
  - All outputs go to reset values immediately; adc_read and adc_enable drop asynchronously.
  - After reset release, operation restarts from IDLE.

## Test plan
- Single cold read: POWER_UP_CYCLES=16, req=01, ADC latency 1000, value 0xA5C3 → adc_read rises 17 cycles after req. ack=01 with result=0xA5C3 and result_error=0, one cycle. Then busy=0 and adc_enable=0.
- Contention: req=11 held and re-asserted after each ack → grants in order 0, 1, 0, 1. Each read gets its own adc_read rising edge, with ≥2 low cycles between reads.
- Timeout: TIMEOUT_CYCLES=64, ADC never completes → ack pulses exactly 64 cycles after adc_read rises, with result_error=1 and result still holding its previous value.
- Warm path: keep_enabled=1, second read on req=10 → adc_read rises 1 cycle after req is sampled, with no power-up delay.
- Abort: drop req[0] 300 cycles into READ → adc_read falls on the next edge, no ack, result unchanged. A late completion pulse is ignored.
- Reset mid-READ: assert rst for 3 cycles → adc_read, adc_enable, busy and ack are 0 immediately. After release, a new read completes normally with requester 0 granted first.
